// File: rtl/mmu_tlb_if.sv
// rtl/mmu_tlb_if.sv - core and register-side signal bundle for mmu_tlb
interface mmu_tlb_if #(
  parameter int RV   = 16,
  parameter int VA   = RV,
  parameter int PA   = RV,
  parameter int ASID = 4
);
  localparam int LSB = RV / 16;

  logic            is_pc;
  logic            is_read;
  logic            is_write;
  logic            mmu_enable;
  logic            mmu_d_proxy;
  logic            supmode;
  logic [ASID-1:0] asid;
  logic [VA-1:LSB] pcv;
  logic [VA-1:LSB] addrv;
  logic [PA-1:LSB] addrp;
  logic            mmu_miss_fault;
  logic            mmu_prot_fault;
  logic            mmu_fault;
  logic            reg_write;
  logic [1:0]      reg_sel;
  logic [RV-1:0]   reg_data;
  logic [RV-1:0]   reg_read;
  logic            mmu_busy;

  // TLB side
  modport slave (
    input  is_pc, is_read, is_write, mmu_enable, mmu_d_proxy, supmode, asid,
    input  pcv, addrv, mmu_fault, reg_write, reg_sel, reg_data,
    output addrp, mmu_miss_fault, mmu_prot_fault, reg_read, mmu_busy
  );

  // core side
  modport master (
    output is_pc, is_read, is_write, mmu_enable, mmu_d_proxy, supmode, asid,
    output pcv, addrv, mmu_fault, reg_write, reg_sel, reg_data,
    input  addrp, mmu_miss_fault, mmu_prot_fault, reg_read, mmu_busy
  );
endinterface

// File: rtl/mmu_tlb.sv
// rtl/mmu_tlb.sv - fully associative ASID-tagged TLB with software refill and flush sequencer
module mmu_tlb #(
  parameter int RV   = 16,
  parameter int VA   = RV,
  parameter int PA   = RV,
  parameter int PAGE = 10,
  parameter int NTLB = 8,
  parameter int ASID = 4
) (
  input  logic      clk,
  input  logic      reset,
  mmu_tlb_if.slave  bus
);
  localparam int LSB = RV / 16;
  localparam int VPN = VA - PAGE;
  localparam int PPN = PA - PAGE;
  localparam int PW  = $clog2(NTLB);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  // flush sequencer
  state_t          state_q, state_d;
  logic [PW-1:0]   fcnt_q, fcnt_d;
  logic            fall_q, fall_d;
  logic [ASID-1:0] fasid_q, fasid_d;

  // entry array
  logic            ent_v_q    [NTLB];
  logic            ent_v_d    [NTLB];
  logic            ent_g_q    [NTLB];
  logic            ent_g_d    [NTLB];
  logic            ent_w_q    [NTLB];
  logic            ent_w_d    [NTLB];
  logic [1:0]      ent_sp_q   [NTLB];
  logic [1:0]      ent_sp_d   [NTLB];
  logic [ASID-1:0] ent_asid_q [NTLB];
  logic [ASID-1:0] ent_asid_d [NTLB];
  logic [VPN-1:0]  ent_vpn_q  [NTLB];
  logic [VPN-1:0]  ent_vpn_d  [NTLB];
  logic [PPN-1:0]  ent_ppn_q  [NTLB];
  logic [PPN-1:0]  ent_ppn_d  [NTLB];

  // replacement pointer, fault and staging-tag registers
  logic [PW-1:0]   victim_q, victim_d;
  logic [VPN-1:0]  fault_vpn_q, fault_vpn_d;
  logic            fault_ins_q, fault_ins_d;
  logic            fault_sup_q, fault_sup_d;
  logic            fault_type_q, fault_type_d;
  logic [VPN-1:0]  tag_vpn_q, tag_vpn_d;
  logic            tag_glb_q, tag_glb_d;
  logic [1:0]      tag_sp_q, tag_sp_d;

  // lookup signals
  logic [VA-1:LSB] taddr;
  logic [VPN-1:0]  t_vpn;
  logic [1:0]      space;
  logic            busy;
  logic            access;
  logic            hit;
  logic [PW-1:0]   hit_idx;
  logic [PPN-1:0]  ppn_hit;
  logic            miss_fault;
  logic            prot_fault;

  // refill slot selection
  logic            tag_hit;
  logic [PW-1:0]   tag_idx;
  logic            inv_found;
  logic [PW-1:0]   inv_idx;
  logic [PW-1:0]   slot;

  logic [RV-1:0]   rd;
  logic            unused_reg_bits;

  // Instruction fetches translate the PC; everything else (incl. writes flagged as pc) uses addrv.
  assign taddr  = (!bus.is_write && bus.is_pc) ? bus.pcv : bus.addrv;
  assign t_vpn  = taddr[VA-1:PAGE];
  assign space  = {bus.is_pc, bus.supmode & ~(bus.mmu_d_proxy & ~bus.is_pc)};
  assign busy   = (state_q == S_FLUSH);
  assign access = bus.is_pc | bus.is_read | bus.is_write;

  // Associative match; scanning downward leaves the lowest matching index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NTLB - 1; i >= 0; i--) begin
      if (ent_v_q[i] && (ent_vpn_q[i] == t_vpn) && (ent_sp_q[i] == space) &&
          (ent_g_q[i] || (ent_asid_q[i] == bus.asid))) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  assign ppn_hit    = hit ? ent_ppn_q[hit_idx] : '0;
  assign miss_fault = bus.mmu_enable & access & (~hit | busy);
  assign prot_fault = bus.mmu_enable & hit & ~busy & bus.is_write & ~bus.is_pc & ~ent_w_q[hit_idx];

  assign bus.addrp          = bus.mmu_enable ? {ppn_hit, taddr[PAGE-1:LSB]} : (PA-LSB)'(taddr);
  assign bus.mmu_miss_fault = miss_fault;
  assign bus.mmu_prot_fault = prot_fault;
  assign bus.mmu_busy       = busy;

  // Refill targets: an entry already holding the staged tag, else the lowest free slot.
  always_comb begin
    tag_hit   = 1'b0;
    tag_idx   = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int i = NTLB - 1; i >= 0; i--) begin
      if (ent_v_q[i] && (ent_vpn_q[i] == tag_vpn_q) && (ent_sp_q[i] == tag_sp_q) &&
          (ent_g_q[i] == tag_glb_q) && (tag_glb_q || (ent_asid_q[i] == bus.asid))) begin
        tag_hit = 1'b1;
        tag_idx = PW'(i);
      end
      if (!ent_v_q[i]) begin
        inv_found = 1'b1;
        inv_idx   = PW'(i);
      end
    end
  end

  // Register read mux; DATA and CTRL both expose busy and the victim pointer.
  always_comb begin
    rd = '0;
    case (bus.reg_sel)
      2'd0: begin
        rd[RV-1 -: VPN] = fault_vpn_q;
        rd[3]           = fault_ins_q;
        rd[2]           = fault_sup_q;
        rd[1]           = fault_type_q;
      end
      2'd1: begin
        rd[RV-1 -: VPN] = tag_vpn_q;
        rd[2]           = tag_glb_q;
        rd[1:0]         = tag_sp_q;
      end
      default: begin
        rd[PW]     = busy;
        rd[PW-1:0] = victim_q;
      end
    endcase
  end

  assign bus.reg_read    = rd;
  assign unused_reg_bits = ^bus.reg_data;

  // Next state: flush sequencing, then fault capture, then register writes (blocked while busy).
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    fall_d       = fall_q;
    fasid_d      = fasid_q;
    ent_v_d      = ent_v_q;
    ent_g_d      = ent_g_q;
    ent_w_d      = ent_w_q;
    ent_sp_d     = ent_sp_q;
    ent_asid_d   = ent_asid_q;
    ent_vpn_d    = ent_vpn_q;
    ent_ppn_d    = ent_ppn_q;
    victim_d     = victim_q;
    fault_vpn_d  = fault_vpn_q;
    fault_ins_d  = fault_ins_q;
    fault_sup_d  = fault_sup_q;
    fault_type_d = fault_type_q;
    tag_vpn_d    = tag_vpn_q;
    tag_glb_d    = tag_glb_q;
    tag_sp_d     = tag_sp_q;
    slot         = victim_q;

    case (state_q)
      S_FLUSH: begin
        if (fall_q || (!ent_g_q[fcnt_q] && (ent_asid_q[fcnt_q] == fasid_q))) begin
          ent_v_d[fcnt_q] = 1'b0;
        end
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q == PW'(NTLB - 1)) begin
          state_d = S_IDLE;
          fcnt_d  = '0;
        end
      end
      default: begin
      end
    endcase

    if (bus.mmu_fault) begin
      fault_vpn_d  = t_vpn;
      fault_ins_d  = bus.is_pc;
      fault_sup_d  = space[0];
      fault_type_d = miss_fault;
      tag_vpn_d    = t_vpn;
      tag_glb_d    = 1'b0;
      tag_sp_d     = space;
    end else if (bus.reg_write && !busy) begin
      case (bus.reg_sel)
        2'd0: begin
          fault_vpn_d  = bus.reg_data[RV-1 -: VPN];
          fault_ins_d  = bus.reg_data[3];
          fault_sup_d  = bus.reg_data[2];
          fault_type_d = bus.reg_data[1];
        end
        2'd1: begin
          tag_vpn_d = bus.reg_data[RV-1 -: VPN];
          tag_glb_d = bus.reg_data[2];
          tag_sp_d  = bus.reg_data[1:0];
        end
        2'd2: begin
          if (tag_hit) begin
            slot = tag_idx;
          end else if (inv_found) begin
            slot = inv_idx;
          end else begin
            slot     = victim_q;
            victim_d = victim_q + 1'b1;
          end
          ent_v_d[slot]    = bus.reg_data[1];
          ent_w_d[slot]    = bus.reg_data[2];
          ent_g_d[slot]    = tag_glb_q;
          ent_sp_d[slot]   = tag_sp_q;
          ent_asid_d[slot] = bus.asid;
          ent_vpn_d[slot]  = tag_vpn_q;
          ent_ppn_d[slot]  = bus.reg_data[RV-1 -: PPN];
        end
        default: begin
          if (bus.reg_data[0] || bus.reg_data[1]) begin
            state_d = S_FLUSH;
            fcnt_d  = '0;
            fall_d  = bus.reg_data[0];
            fasid_d = bus.reg_data[4 +: ASID];
          end
        end
      endcase
    end
  end

  // State registers; reset also aborts any flush in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fcnt_q       <= '0;
      fall_q       <= 1'b0;
      fasid_q      <= '0;
      victim_q     <= '0;
      fault_vpn_q  <= '0;
      fault_ins_q  <= 1'b0;
      fault_sup_q  <= 1'b0;
      fault_type_q <= 1'b0;
      tag_vpn_q    <= '0;
      tag_glb_q    <= 1'b0;
      tag_sp_q     <= '0;
      for (int i = 0; i < NTLB; i++) begin
        ent_v_q[i]    <= 1'b0;
        ent_g_q[i]    <= 1'b0;
        ent_w_q[i]    <= 1'b0;
        ent_sp_q[i]   <= '0;
        ent_asid_q[i] <= '0;
        ent_vpn_q[i]  <= '0;
        ent_ppn_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      fall_q       <= fall_d;
      fasid_q      <= fasid_d;
      victim_q     <= victim_d;
      fault_vpn_q  <= fault_vpn_d;
      fault_ins_q  <= fault_ins_d;
      fault_sup_q  <= fault_sup_d;
      fault_type_q <= fault_type_d;
      tag_vpn_q    <= tag_vpn_d;
      tag_glb_q    <= tag_glb_d;
      tag_sp_q     <= tag_sp_d;
      ent_v_q      <= ent_v_d;
      ent_g_q      <= ent_g_d;
      ent_w_q      <= ent_w_d;
      ent_sp_q     <= ent_sp_d;
      ent_asid_q   <= ent_asid_d;
      ent_vpn_q    <= ent_vpn_d;
      ent_ppn_q    <= ent_ppn_d;
    end
  end
endmodule

// File: tb/tb_mmu_tlb.sv
// tb/tb_mmu_tlb.sv - directed self-checking bench for mmu_tlb
module tb_mmu_tlb;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  mmu_tlb_if #(.RV(16), .VA(16), .PA(16), .ASID(4)) tb_bus ();

  mmu_tlb #(.RV(16), .VA(16), .PA(16), .PAGE(10), .NTLB(8), .ASID(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tb_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [15:0] data);
    tb_bus.reg_sel   = sel;
    tb_bus.reg_data  = data;
    tb_bus.reg_write = 1'b1;
    step();
    tb_bus.reg_write = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] sel, input logic [15:0] exp);
    tb_bus.reg_sel = sel;
    #1;
    chk(tag, tb_bus.reg_read, exp);
  endtask

  task automatic commit(input logic [15:0] tag, input logic [15:0] data, input logic [3:0] as);
    tb_bus.asid = as;
    wr(2'd1, tag);
    wr(2'd2, data);
  endtask

  task automatic acc(input logic pc, input logic r, input logic w, input logic sup,
                     input logic prx, input logic [15:0] a, input logic [3:0] as);
    tb_bus.is_pc       = pc;
    tb_bus.is_read     = r;
    tb_bus.is_write    = w;
    tb_bus.supmode     = sup;
    tb_bus.mmu_d_proxy = prx;
    tb_bus.pcv         = a[15:1];
    tb_bus.addrv       = a[15:1];
    tb_bus.asid        = as;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    tb_bus.is_pc = 0; tb_bus.is_read = 0; tb_bus.is_write = 0;
    tb_bus.mmu_enable = 0; tb_bus.mmu_d_proxy = 0; tb_bus.supmode = 0;
    tb_bus.asid = 0; tb_bus.pcv = 0; tb_bus.addrv = 0; tb_bus.mmu_fault = 0;
    tb_bus.reg_write = 0; tb_bus.reg_sel = 0; tb_bus.reg_data = 0;
    step();
    step();
    rd_chk("rst_fault_reg", 2'd0, 16'h0000);
    rd_chk("rst_tag_reg",   2'd1, 16'h0000);
    rd_chk("rst_data_reg",  2'd2, 16'h0000);
    rd_chk("rst_ctrl_reg",  2'd3, 16'h0000);
    reset = 1'b0;
    step();

    // 1: translation disabled passes the address through
    acc(0, 1, 0, 1, 0, 16'h1234, 4'd0);
    chk("t1_addrp", {tb_bus.addrp, 1'b0}, 16'h1234);
    chk("t1_miss",  tb_bus.mmu_miss_fault, 1'b0);
    chk("t1_prot",  tb_bus.mmu_prot_fault, 1'b0);

    // 2: single supervisor data entry with ASID 2
    tb_bus.mmu_enable = 1'b1;
    commit(16'h0C01, 16'h5406, 4'd2);
    acc(0, 1, 0, 1, 0, 16'h0C10, 4'd2);
    chk("t2_addrp", {tb_bus.addrp, 1'b0}, 16'h5410);
    chk("t2_miss",  tb_bus.mmu_miss_fault, 1'b0);
    chk("t2_prot",  tb_bus.mmu_prot_fault, 1'b0);
    acc(0, 1, 0, 1, 0, 16'h0C10, 4'd5);
    chk("t2_asid_miss",  tb_bus.mmu_miss_fault, 1'b1);
    chk("t2_asid_addrp", {tb_bus.addrp, 1'b0}, 16'h0010);
    acc(0, 1, 0, 0, 0, 16'h0C10, 4'd2);
    chk("t2_user_miss",  tb_bus.mmu_miss_fault, 1'b1);

    // 3: fill NTLB+2 tags, round-robin replacement, in-place overwrite
    do_reset();
    for (int i = 0; i < 10; i++) begin
      commit(16'((10 + i) << 10) | 16'h0001, 16'((32 + i) << 10) | 16'h0006, 4'd1);
    end
    rd_chk("t3_victim", 2'd2, 16'h0002);
    acc(0, 1, 0, 1, 0, 16'h2800, 4'd1);
    chk("t3_vpn10_gone", tb_bus.mmu_miss_fault, 1'b1);
    acc(0, 1, 0, 1, 0, 16'h4800, 4'd1);
    chk("t3_vpn18_addrp", {tb_bus.addrp, 1'b0}, 16'hA000);
    acc(0, 1, 0, 1, 0, 16'h4400, 4'd1);
    chk("t3_vpn17_addrp", {tb_bus.addrp, 1'b0}, 16'h9C00);
    commit(16'h3C01, 16'hFC06, 4'd1);
    rd_chk("t3_victim_kept", 2'd2, 16'h0002);
    acc(0, 1, 0, 1, 0, 16'h3C00, 4'd1);
    chk("t3_vpn15_new", {tb_bus.addrp, 1'b0}, 16'hFC00);
    acc(0, 1, 0, 1, 0, 16'h3000, 4'd1);
    chk("t3_vpn12_kept", {tb_bus.addrp, 1'b0}, 16'h8800);

    // 4: protection fault, fault capture, instruction space miss
    do_reset();
    commit(16'h1401, 16'h1C02, 4'd0);
    acc(0, 0, 1, 1, 0, 16'h1420, 4'd0);
    chk("t4_prot",  tb_bus.mmu_prot_fault, 1'b1);
    chk("t4_nomiss", tb_bus.mmu_miss_fault, 1'b0);
    chk("t4_addrp", {tb_bus.addrp, 1'b0}, 16'h1C20);
    tb_bus.mmu_fault = 1'b1;
    tb_bus.reg_sel   = 2'd1;
    tb_bus.reg_data  = 16'hFFFF;
    tb_bus.reg_write = 1'b1;
    step();
    tb_bus.mmu_fault = 1'b0;
    tb_bus.reg_write = 1'b0;
    rd_chk("t4_fault_reg", 2'd0, 16'h1404);
    rd_chk("t4_tag_reg",   2'd1, 16'h1401);
    acc(0, 1, 0, 1, 0, 16'h1420, 4'd0);
    chk("t4_read_noprot", tb_bus.mmu_prot_fault, 1'b0);
    acc(1, 0, 0, 1, 0, 16'h1420, 4'd0);
    tb_bus.addrv = 15'h0;
    #1;
    chk("t4_pc_miss", tb_bus.mmu_miss_fault, 1'b1);
    tb_bus.mmu_fault = 1'b1;
    step();
    tb_bus.mmu_fault = 1'b0;
    rd_chk("t4_fault_pc", 2'd0, 16'h140E);
    rd_chk("t4_tag_pc",   2'd1, 16'h1403);
    acc(0, 1, 0, 1, 1, 16'h1420, 4'd0);
    chk("t4_proxy_miss", tb_bus.mmu_miss_fault, 1'b1);

    // 5: per-ASID flush keeps global and other-ASID entries
    do_reset();
    commit(16'h0405, 16'h4406, 4'd2);
    commit(16'h0801, 16'h4806, 4'd2);
    commit(16'h0C01, 16'h4C06, 4'd3);
    commit(16'h1001, 16'h5006, 4'd2);
    wr(2'd3, 16'h0022);
    n = 0;
    while (tb_bus.mmu_busy && n < 20) begin
      n++;
      if (n == 2) begin
        acc(0, 1, 0, 1, 0, 16'h0400, 4'd2);
        chk("t5_busy_miss", tb_bus.mmu_miss_fault, 1'b1);
        rd_chk("t5_busy_ctrl", 2'd3, 16'h0008);
        tb_bus.reg_sel   = 2'd1;
        tb_bus.reg_data  = 16'h3C01;
        tb_bus.reg_write = 1'b1;
      end
      step();
      tb_bus.reg_write = 1'b0;
    end
    chk("t5_busy_cycles", n, 8);
    chk("t5_idle", tb_bus.mmu_busy, 1'b0);
    rd_chk("t5_tag_unchanged", 2'd1, 16'h1001);
    acc(0, 1, 0, 1, 0, 16'h0400, 4'd7);
    chk("t5_global_addrp", {tb_bus.addrp, 1'b0}, 16'h4400);
    chk("t5_global_hit", tb_bus.mmu_miss_fault, 1'b0);
    acc(0, 1, 0, 1, 0, 16'h0C00, 4'd3);
    chk("t5_asid3_addrp", {tb_bus.addrp, 1'b0}, 16'h4C00);
    acc(0, 1, 0, 1, 0, 16'h0800, 4'd2);
    chk("t5_asid2_gone", tb_bus.mmu_miss_fault, 1'b1);
    acc(0, 1, 0, 1, 0, 16'h1000, 4'd2);
    chk("t5_asid2b_gone", tb_bus.mmu_miss_fault, 1'b1);

    // 6: reset in the middle of a flush-all
    do_reset();
    for (int i = 0; i < 9; i++) begin
      commit(16'((20 + i) << 10) | 16'h0001, 16'((48 + i) << 10) | 16'h0006, 4'd1);
    end
    rd_chk("t6_victim_pre", 2'd2, 16'h0001);
    acc(0, 1, 0, 1, 0, 16'h6C00, 4'd1);
    chk("t6_vpn27_pre", {tb_bus.addrp, 1'b0}, 16'hDC00);
    wr(2'd3, 16'h0001);
    chk("t6_busy1", tb_bus.mmu_busy, 1'b1);
    step();
    step();
    chk("t6_busy3", tb_bus.mmu_busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_busy_after", tb_bus.mmu_busy, 1'b0);
    rd_chk("t6_victim_rst", 2'd2, 16'h0000);
    acc(0, 1, 0, 1, 0, 16'h6C00, 4'd1);
    chk("t6_vpn27_miss", tb_bus.mmu_miss_fault, 1'b1);
    acc(0, 1, 0, 1, 0, 16'h7000, 4'd1);
    chk("t6_vpn28_miss", tb_bus.mmu_miss_fault, 1'b1);
    step();
    chk("t6_still_idle", tb_bus.mmu_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
